// File: rtl/replica_pkg.sv
// Shared types and helpers for the replica-exchange annealing array and its
// top-level phase scheduler.
package replica_pkg;

  typedef enum logic [1:0] {
    NOP  = 2'd0,
    SELF = 2'd1,
    PREV = 2'd2,
    FOLW = 2'd3
  } exchange_command_t;

  typedef enum logic [1:0] {
    THR = 2'd0,
    OR0 = 2'd1,
    OR1 = 2'd2
  } opt_command_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    OPT    = 3'd1,
    EXCH   = 3'd2,
    SETTLE = 3'd3,
    DONE   = 3'd4
  } sched_state_t;

  localparam logic [31:0] XORSHIFT_SEED = 32'h2545_F491;

  function automatic logic [31:0] xorshift32_next(input logic [31:0] x);
    logic [31:0] v;
    v = x;
    v = v ^ (v << 13);
    v = v ^ (v >> 17);
    v = v ^ (v << 5);
    return v;
  endfunction

endpackage

// File: rtl/replica_xorshift32.sv
// Free-running-on-enable xorshift32 generator; the register itself is the
// output, so the advanced value appears in the cycle after en is sampled.
module replica_xorshift32
  import replica_pkg::*;
#(
  parameter logic [31:0] SEED = XORSHIFT_SEED
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  output logic [31:0] q
);

  logic [31:0] q_q;

  // Generator state: seeded on reset, one step per enabled cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_q <= SEED;
    end else if (en) begin
      q_q <= xorshift32_next(q_q);
    end else begin
      q_q <= q_q;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/replica_exchange_sched.sv
// Phase sequencer: alternates opt_len THR cycles with a single OR0/OR1
// exchange slot plus EXCH_LAT settle cycles, for iter_num iterations per run.
module replica_exchange_sched
  import replica_pkg::*;
#(
  parameter int unsigned replica_num = 32,
  parameter int unsigned EXCH_LAT    = 2,
  parameter logic [31:0] SEED        = XORSHIFT_SEED
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [15:0]       iter_num,
  input  logic [15:0]       opt_len,
  output exchange_command_t in_exchange,
  output opt_command_t      opt_command,
  output logic [31:0]       r_exchange,
  output logic              busy,
  output logic              done,
  output logic [15:0]       iter_cnt
);

  localparam logic [15:0] SETTLE_LOAD = 16'(EXCH_LAT - 32'd1);

  if (replica_num < 32'd2 || EXCH_LAT < 32'd1) begin : g_bad_params
    $error("replica_exchange_sched needs replica_num >= 2 and EXCH_LAT >= 1");
  end

  sched_state_t      state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [15:0]       iter_cnt_q, iter_cnt_d;
  logic [15:0]       iter_num_q, iter_num_d;
  logic [15:0]       opt_len_q, opt_len_d;
  logic              phase_q, phase_d;
  logic [15:0]       iter_inc_s;
  exchange_command_t in_exchange_q;
  opt_command_t      opt_command_q;
  logic              busy_q, done_q;

  assign iter_inc_s = iter_cnt_q + 16'd1;

  // Next-state, down-counter and run bookkeeping.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    iter_cnt_d = iter_cnt_q;
    iter_num_d = iter_num_q;
    opt_len_d  = opt_len_q;
    phase_d    = phase_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          iter_num_d = iter_num;
          opt_len_d  = opt_len;
          iter_cnt_d = 16'd0;
          phase_d    = 1'b0;
          if (iter_num == 16'd0) begin
            state_d = DONE;
          end else if (opt_len == 16'd0) begin
            state_d = EXCH;
          end else begin
            state_d = OPT;
            cnt_d   = opt_len - 16'd1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      OPT: begin
        if (cnt_q == 16'd0) begin
          state_d = EXCH;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      EXCH: begin
        phase_d = ~phase_q;
        state_d = SETTLE;
        cnt_d   = SETTLE_LOAD;
      end
      SETTLE: begin
        if (cnt_q != 16'd0) begin
          cnt_d = cnt_q - 16'd1;
        end else begin
          iter_cnt_d = iter_inc_s;
          // stop only takes effect here, so a slot or OPT burst is never cut short
          if (iter_inc_s == iter_num_q || stop) begin
            state_d = DONE;
          end else if (opt_len_q == 16'd0) begin
            state_d = EXCH;
          end else begin
            state_d = OPT;
            cnt_d   = opt_len_q - 16'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters and outputs; outputs are decoded from the next state so
  // they line up with the state they describe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= 16'd0;
      iter_cnt_q    <= 16'd0;
      iter_num_q    <= 16'd0;
      opt_len_q     <= 16'd0;
      phase_q       <= 1'b0;
      in_exchange_q <= NOP;
      opt_command_q <= THR;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      iter_cnt_q    <= iter_cnt_d;
      iter_num_q    <= iter_num_d;
      opt_len_q     <= opt_len_d;
      phase_q       <= phase_d;
      in_exchange_q <= (state_d == EXCH) ? SELF : NOP;
      opt_command_q <= (state_d != EXCH) ? THR : (phase_d ? OR1 : OR0);
      busy_q        <= (state_d == OPT) || (state_d == EXCH) || (state_d == SETTLE);
      done_q        <= (state_d == DONE);
    end
  end

  replica_xorshift32 #(
    .SEED (SEED)
  ) u_rng (
    .clk   (clk),
    .reset (reset),
    .en    (state_d == EXCH),
    .q     (r_exchange)
  );

  assign in_exchange = in_exchange_q;
  assign opt_command = opt_command_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign iter_cnt    = iter_cnt_q;

endmodule

// File: tb/tb_replica_exchange_sched.sv
// Directed bench for replica_exchange_sched: run shapes, slot commands,
// random stream continuity, stop, ignored starts and mid-run reset.
module tb_replica_exchange_sched;
  import replica_pkg::*;

  logic              clk;
  logic              reset;
  logic              start;
  logic              stop;
  logic [15:0]       iter_num;
  logic [15:0]       opt_len;
  exchange_command_t in_exchange;
  opt_command_t      opt_command;
  logic [31:0]       r_exchange;
  logic              busy;
  logic              done;
  logic [15:0]       iter_cnt;

  int          n_cmp;
  int          n_bad;
  logic [31:0] model_r;

  int          n_busy, n_done, done_idx, n_slots, r_bad, cmd_bad;
  int          slot_idx [8];
  logic [1:0]  slot_cmd [8];
  logic [31:0] slot_r   [8];
  logic [15:0] iter_at_done;

  replica_exchange_sched #(
    .replica_num (32),
    .EXCH_LAT    (2),
    .SEED        (32'h2545_F491)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .iter_num    (iter_num),
    .opt_len     (opt_len),
    .in_exchange (in_exchange),
    .opt_command (opt_command),
    .r_exchange  (r_exchange),
    .busy        (busy),
    .done        (done),
    .iter_cnt    (iter_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] xs32(input logic [31:0] x);
    logic [31:0] v;
    v = x;
    v = v ^ (v << 13);
    v = v ^ (v >> 17);
    v = v ^ (v << 5);
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [15:0] it, input logic [15:0] len);
    iter_num = it;
    opt_len  = len;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  // Samples cycle 1.. after the start edge until done or the budget runs out.
  task automatic capture(input int max_cyc, input int stop_at, input int ign_at);
    logic [31:0] prev_r;
    n_busy = 0; n_done = 0; done_idx = 0; n_slots = 0; r_bad = 0; cmd_bad = 0;
    iter_at_done = 16'hFFFF;
    prev_r = model_r;
    for (int i = 1; i <= max_cyc; i++) begin
      if (busy) n_busy++;
      if (in_exchange == SELF) begin
        if (opt_command == THR) cmd_bad++;
        if (n_slots < 8) begin
          slot_idx[n_slots] = i;
          slot_cmd[n_slots] = opt_command;
          slot_r[n_slots]   = r_exchange;
        end
        n_slots++;
      end else begin
        if (r_exchange !== prev_r) r_bad++;
        if (opt_command != THR) cmd_bad++;
      end
      prev_r = r_exchange;
      if (done) begin
        n_done++;
        done_idx     = i;
        iter_at_done = iter_cnt;
        break;
      end
      if (i == stop_at) stop = 1'b1;
      if (i == ign_at) begin
        iter_num = 16'd1;
        start    = 1'b1;
      end
      tick();
      start = 1'b0;
    end
  endtask

  task automatic check_slots(input string tag, input int first, input int count, input int spacing);
    for (int k = 0; k < count; k++) begin
      model_r = xs32(model_r);
      chk($sformatf("%s_slot%0d_idx", tag, k), 32'(slot_idx[k]), 32'(first + k * spacing));
      chk($sformatf("%s_slot%0d_r", tag, k), slot_r[k], model_r);
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    reset = 1'b1; start = 1'b0; stop = 1'b0;
    iter_num = 16'd0; opt_len = 16'd0;
    model_r = 32'h2545_F491;
    #12;
    reset = 1'b0;
    tick();

    chk("rst_in_exchange", 32'(in_exchange), 32'(NOP));
    chk("rst_opt_command", 32'(opt_command), 32'(THR));
    chk("rst_r_exchange", r_exchange, 32'h2545_F491);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_iter_cnt", 32'(iter_cnt), 32'd0);

    // Run A: 3 iterations x (4 THR + 1 slot + 2 settle)
    pulse_start(16'd3, 16'd4);
    capture(60, 0, 0);
    chk("a_busy_cycles", 32'(n_busy), 32'd21);
    chk("a_done_idx", 32'(done_idx), 32'd22);
    chk("a_iter_cnt", 32'(iter_at_done), 32'd3);
    chk("a_n_slots", 32'(n_slots), 32'd3);
    chk("a_r_steady", 32'(r_bad), 32'd0);
    chk("a_cmd_pairing", 32'(cmd_bad), 32'd0);
    chk("a_cmd0", 32'(slot_cmd[0]), 32'(OR0));
    chk("a_cmd1", 32'(slot_cmd[1]), 32'(OR1));
    chk("a_cmd2", 32'(slot_cmd[2]), 32'(OR0));
    check_slots("a", 5, 3, 7);
    chk("a_busy_in_done", 32'(busy), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("a_done_single", 32'(done), 32'd0);
    chk("a_start_in_done_ignored", 32'(busy), 32'd0);
    tick();
    chk("a_still_idle", 32'(busy), 32'd0);
    chk("a_iter_cnt_hold", 32'(iter_cnt), 32'd3);

    // Run B: zero iterations
    pulse_start(16'd0, 16'd4);
    capture(10, 0, 0);
    chk("b_done_idx", 32'(done_idx), 32'd1);
    chk("b_n_slots", 32'(n_slots), 32'd0);
    chk("b_busy_cycles", 32'(n_busy), 32'd0);
    chk("b_iter_cnt", 32'(iter_at_done), 32'd0);
    tick();

    // Run C: opt_len = 0, back-to-back slots, stream continues from run A
    pulse_start(16'd2, 16'd0);
    capture(30, 0, 0);
    chk("c_done_idx", 32'(done_idx), 32'd7);
    chk("c_busy_cycles", 32'(n_busy), 32'd6);
    chk("c_n_slots", 32'(n_slots), 32'd2);
    chk("c_cmd0", 32'(slot_cmd[0]), 32'(OR0));
    chk("c_cmd1", 32'(slot_cmd[1]), 32'(OR1));
    chk("c_iter_cnt", 32'(iter_at_done), 32'd2);
    chk("c_r_steady", 32'(r_bad), 32'd0);
    check_slots("c", 1, 2, 3);
    tick();

    // Run D: stop raised in iteration 2 OPT, start pulse while busy
    pulse_start(16'd10, 16'd3);
    capture(80, 8, 3);
    stop = 1'b0;
    chk("d_done_idx", 32'(done_idx), 32'd13);
    chk("d_iter_cnt", 32'(iter_at_done), 32'd2);
    chk("d_n_slots", 32'(n_slots), 32'd2);
    chk("d_cmd0", 32'(slot_cmd[0]), 32'(OR0));
    chk("d_cmd1", 32'(slot_cmd[1]), 32'(OR1));
    chk("d_busy_cycles", 32'(n_busy), 32'd12);
    check_slots("d", 4, 2, 6);
    tick();

    // Run E: reset asserted during the first exchange slot
    pulse_start(16'd2, 16'd2);
    tick();
    tick();
    chk("e_in_slot", 32'(in_exchange), 32'(SELF));
    #2;
    reset = 1'b1;
    #1;
    chk("e_rst_in_exchange", 32'(in_exchange), 32'(NOP));
    chk("e_rst_opt_command", 32'(opt_command), 32'(THR));
    chk("e_rst_r_exchange", r_exchange, 32'h2545_F491);
    chk("e_rst_busy", 32'(busy), 32'd0);
    chk("e_rst_done", 32'(done), 32'd0);
    chk("e_rst_iter_cnt", 32'(iter_cnt), 32'd0);
    tick();
    reset = 1'b0;
    n_done = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done) n_done++;
    end
    chk("e_no_done_after_reset", 32'(n_done), 32'd0);
    model_r = 32'h2545_F491;
    pulse_start(16'd1, 16'd1);
    capture(20, 0, 0);
    chk("e_fresh_done_idx", 32'(done_idx), 32'd5);
    chk("e_fresh_cmd0", 32'(slot_cmd[0]), 32'(OR0));
    chk("e_fresh_iter_cnt", 32'(iter_at_done), 32'd1);
    check_slots("e", 2, 1, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
